// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants and the raster counter type.
package vga_pkg;
  localparam int CNT_W = 10;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BACK_DEF = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BACK_DEF = 33;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/vga_axis.sv
// vga_axis: one raster axis, a wrapping counter with active/sync window decode.
module vga_axis
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FRONT = H_FRONT_DEF,
  parameter int SYNC = H_SYNC_DEF,
  parameter int BACK = H_BACK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_adv,
  output cnt_t o_cnt,
  output logic o_active,
  output logic o_sync,
  output logic o_wrap
);
  localparam cnt_t LAST = cnt_t'(ACTIVE + FRONT + SYNC + BACK - 1);
  localparam cnt_t ACT_END = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_BEG = cnt_t'(ACTIVE + FRONT);
  localparam cnt_t SYNC_END = cnt_t'(ACTIVE + FRONT + SYNC);
  cnt_t r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_adv) r_cnt <= o_wrap ? '0 : r_cnt + cnt_t'(1);
  end
  assign o_cnt = r_cnt;
  assign o_wrap = r_cnt == LAST;
  assign o_active = r_cnt < ACT_END;
  assign o_sync = r_cnt >= SYNC_BEG && r_cnt < SYNC_END;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster generator; outputs are a registered decode of the
// current counters, so they trail the counters by one enabled clock.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BACK = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT = V_FRONT_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BACK = V_BACK_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] xpos,
  output logic [CNT_W-1:0] ypos,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) || H_ACTIVE == 0 || H_FRONT == 0 ||
      H_SYNC == 0 || H_BACK == 0 || V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 ||
      V_BACK == 0) begin : g_bad_timing
    $error("vga_timing: zero interval or total exceeds counter range");
  end
  cnt_t w_hcnt, w_vcnt;
  logic w_h_act, w_h_sync, w_h_wrap, w_v_act, w_v_sync, w_unused_v_wrap;
  logic r_hsync, r_vsync, r_active, r_line_start, r_frame_start;
  cnt_t r_xpos, r_ypos;
  vga_axis #(.ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)) u_h (
    .clk(clk), .rst(reset), .i_adv(enable),
    .o_cnt(w_hcnt), .o_active(w_h_act), .o_sync(w_h_sync), .o_wrap(w_h_wrap)
  );
  vga_axis #(.ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)) u_v (
    .clk(clk), .rst(reset), .i_adv(enable & w_h_wrap),
    .o_cnt(w_vcnt), .o_active(w_v_act), .o_sync(w_v_sync), .o_wrap(w_unused_v_wrap)
  );
  // Decoding only on enabled clocks makes each position produce exactly one strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_active <= 1'b0;
      r_xpos <= '0;
      r_ypos <= '0;
      r_line_start <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (enable) begin
      r_hsync <= w_h_sync ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_v_sync ? SYNC_POL : ~SYNC_POL;
      r_active <= w_h_act & w_v_act;
      r_xpos <= w_hcnt;
      r_ypos <= w_vcnt;
      r_line_start <= w_hcnt == '0;
      r_frame_start <= w_hcnt == '0 && w_vcnt == '0;
    end else begin
      r_line_start <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end
  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign active = r_active;
  assign xpos = r_xpos;
  assign ypos = r_ypos;
  assign line_start = r_line_start;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of the default 640x480 raster and of a tiny
// active-high-sync raster small enough to run whole frames.
module tb_vga_timing;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, s_reset = 1'b1, s_enable = 1'b1;
  logic hsync, vsync, active, line_start, frame_start;
  logic s_hsync, s_vsync, s_active, s_line_start, s_frame_start;
  logic [9:0] xpos, ypos, s_xpos, s_ypos;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  vga_timing u_dut (
    .clk(clk), .reset(reset), .enable(enable), .hsync(hsync), .vsync(vsync),
    .active(active), .xpos(xpos), .ypos(ypos), .line_start(line_start),
    .frame_start(frame_start)
  );
  vga_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .reset(s_reset), .enable(s_enable), .hsync(s_hsync), .vsync(s_vsync),
    .active(s_active), .xpos(s_xpos), .ypos(s_ypos), .line_start(s_line_start),
    .frame_start(s_frame_start)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    int act_cnt = 0, first_inact = -1, ls2 = -1, ls_cnt = 0, hs_cnt = 0, hs_x = -1;
    int fs_cnt = 0, vs_cnt = 0, y801 = -1;
    int s_act = 0, s_hs = 0, s_hs_x = -1, s_vs = 0, s_vs_y = -1, s_fs = 0, s_fs2 = -1;
    int s_ymax = 0, hold_fs = 0;
    repeat (3) tick();
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_active", active, 0);
    chk("rst_xpos", xpos, 0);
    chk("rst_ypos", ypos, 0);
    chk("rst_line_start", line_start, 0);
    chk("rst_frame_start", frame_start, 0);
    reset = 1'b0;
    for (int c = 1; c <= 1700; c++) begin
      tick();
      if (c == 1) begin
        chk("c1_frame_start", frame_start, 1);
        chk("c1_line_start", line_start, 1);
        chk("c1_active", active, 1);
        chk("c1_xpos", xpos, 0);
        chk("c1_ypos", ypos, 0);
      end
      if (c <= 800) begin
        act_cnt += int'(active);
        if (!active && first_inact < 0) first_inact = c;
        hs_cnt += int'(!hsync);
        if (!hsync && hs_x < 0) hs_x = int'(xpos);
      end
      if (c > 1 && line_start && ls2 < 0) ls2 = c;
      if (c > 1) fs_cnt += int'(frame_start);
      ls_cnt += int'(line_start);
      vs_cnt += int'(!vsync);
      if (c == 801) y801 = int'(ypos);
    end
    chk("line_active_cnt", act_cnt, 640);
    chk("first_blank_clk", first_inact, 641);
    chk("line_start_period", ls2, 801);
    chk("line_start_cnt", ls_cnt, 3);
    chk("hsync_low_cnt", hs_cnt, 96);
    chk("hsync_start_x", hs_x, 656);
    chk("no_extra_frame_start", fs_cnt, 0);
    chk("vsync_idle", vs_cnt, 0);
    chk("ypos_line1", y801, 1);
    tick();
    chk("pre_hold_x", xpos, 100);
    chk("pre_hold_y", ypos, 2);
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("hold_x", xpos, 100);
      chk("hold_strobes", int'(line_start | frame_start), 0);
    end
    chk("hold_active", active, 1);
    chk("hold_y", ypos, 2);
    chk("hold_hsync", hsync, 1);
    enable = 1'b1;
    tick();
    chk("resume_x", xpos, 101);
    tick();
    chk("resume_x2", xpos, 102);
    repeat (598) tick();
    chk("in_hsync_x", xpos, 700);
    chk("in_hsync_low", hsync, 0);
    reset = 1'b1;
    tick();
    chk("rst_mid_hsync", hsync, 1);
    chk("rst_mid_x", xpos, 0);
    chk("rst_mid_active", active, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("restart_x", xpos, 0);
    chk("restart_y", ypos, 0);
    chk("restart_fs", frame_start, 1);
    chk("restart_ls", line_start, 1);
    chk("restart_active", active, 1);
    tick();
    chk("restart_x1", xpos, 1);
    chk("restart_fs_off", frame_start, 0);
    chk("s_rst_hsync", s_hsync, 0);
    chk("s_rst_vsync", s_vsync, 0);
    s_reset = 1'b0;
    for (int c = 1; c <= 360; c++) begin
      tick();
      if (c <= 120) begin
        s_act += int'(s_active);
        s_vs += int'(s_vsync);
        if (s_vsync && s_vs_y < 0) s_vs_y = int'(s_ypos);
      end
      if (c <= 15) begin
        s_hs += int'(s_hsync);
        if (s_hsync && s_hs_x < 0) s_hs_x = int'(s_xpos);
      end
      if (c == 120) begin
        chk("s_last_x", s_xpos, 14);
        chk("s_last_y", s_ypos, 7);
      end
      if (c > 1 && s_frame_start && s_fs2 < 0) s_fs2 = c;
      s_fs += int'(s_frame_start);
      if (int'(s_ypos) > s_ymax) s_ymax = int'(s_ypos);
    end
    chk("s_active_cnt", s_act, 32);
    chk("s_hsync_cnt", s_hs, 3);
    chk("s_hsync_x", s_hs_x, 10);
    chk("s_vsync_cnt", s_vs, 30);
    chk("s_vsync_y", s_vs_y, 5);
    chk("s_frame_period", s_fs2, 121);
    chk("s_frame_cnt", s_fs, 3);
    chk("s_ymax", s_ymax, 7);
    s_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      hold_fs += int'(s_frame_start);
      chk("s_hold_x", s_xpos, 14);
    end
    s_enable = 1'b1;
    tick();
    hold_fs += int'(s_frame_start);
    chk("s_wrap_x", s_xpos, 0);
    chk("s_wrap_y", s_ypos, 0);
    tick();
    hold_fs += int'(s_frame_start);
    chk("s_after_wrap_x", s_xpos, 1);
    chk("s_fs_once", hold_fs, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
